cpu_if: RTL and testbench

Instruction fetch stage of the PLP 5-stage pipeline, directly upstream of decode.
- Owns the PC and drives a request/ready instruction-memory port.
- Presents one registered instruction and its PC+4 per cycle to decode.
- Holds its outputs while decode signals a load-use stall, and flushes to a NOP bubble on a jump/branch redirect from execute.
- Absorbs variable memory latency with a one-entry skid buffer and a kill state for in-flight fetches.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/cpu_if_skid.sv | 33 +++
 rtl/cpu_if.sv | 177 +++++++++++++++++
 tb/tb_cpu_if.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the PLP instruction fetch stage: state encoding,
// reset/bubble constants and the word-alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_KILL  = 2'd1,
    S_SKID  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] CPU_NOP_INST     = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] CPU_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/cpu_if_skid.sv
// One-entry holding register for an instruction/PC pair that arrived while
// decode was stalled. Load captures, consume or clear empties it.
module cpu_if_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_consume,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clear || i_consume) begin
      r_inst <= '0;
      r_pc   <= '0;
    end else if (i_load) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end
  end

  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

// File: rtl/cpu_if.sv
// PLP instruction fetch stage: owns the PC, drives the req/rdy instruction
// memory port, and feeds decode. Optional counters under CPU_IF_PERF_EN.
module cpu_if
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = CPU_RESET_VECTOR,
  parameter logic [31:0] NOP_INST     = CPU_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  input  logic        imem_rdy,
  output logic [31:0] p_pc,
  output logic [31:0] p_inst
`ifdef CPU_IF_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_kill_tgt;
  logic [31:0]  r_p_pc;
  logic [31:0]  r_p_inst;

  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_kill_tgt_nxt;
  logic [31:0]  w_p_pc_nxt;
  logic [31:0]  w_p_inst_nxt;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_target;
  logic         w_flush;
  logic         w_skid_load;
  logic         w_skid_consume;
  logic         w_skid_clear;
  logic [31:0]  w_skid_inst;
  logic [31:0]  w_skid_pc;

  assign w_pc_inc  = r_pc + 32'd4;
  assign w_target  = word_align(ex_target);
  assign imem_addr = word_align(r_pc);
  assign imem_req  = !rst && (r_state != S_SKID);
  assign p_pc      = r_p_pc;
  assign p_inst    = r_p_inst;

  cpu_if_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_skid_load),
    .i_consume (w_skid_consume),
    .i_clear   (w_skid_clear),
    .i_inst    (imem_data),
    .i_pc      (w_pc_inc),
    .o_inst    (w_skid_inst),
    .o_pc      (w_skid_pc)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_tgt_nxt = r_kill_tgt;
    w_p_pc_nxt     = r_p_pc;
    w_p_inst_nxt   = r_p_inst;
    w_flush        = 1'b0;
    w_skid_load    = 1'b0;
    w_skid_consume = 1'b0;
    w_skid_clear   = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (ex_redirect) begin
          w_flush = 1'b1;
          if (imem_rdy) begin
            w_pc_nxt = w_target;
          end else begin
            // Request must stay stable at the old pc until it completes.
            w_kill_tgt_nxt = w_target;
            w_state_nxt    = S_KILL;
          end
        end else if (imem_rdy) begin
          w_pc_nxt = w_pc_inc;
          if (c_stall) begin
            w_skid_load = 1'b1;
            w_state_nxt = S_SKID;
          end else begin
            w_p_inst_nxt = imem_data;
            w_p_pc_nxt   = w_pc_inc;
          end
        end else if (!c_stall) begin
          w_flush = 1'b1;
        end
      end

      S_KILL: begin
        if (ex_redirect) begin
          w_kill_tgt_nxt = w_target;
        end
        if (imem_rdy) begin
          w_pc_nxt    = ex_redirect ? w_target : r_kill_tgt;
          w_state_nxt = S_FETCH;
        end
      end

      S_SKID: begin
        if (ex_redirect) begin
          w_skid_clear = 1'b1;
          w_pc_nxt     = w_target;
          w_flush      = 1'b1;
          w_state_nxt  = S_FETCH;
        end else if (!c_stall) begin
          w_skid_consume = 1'b1;
          w_p_inst_nxt   = w_skid_inst;
          w_p_pc_nxt     = w_skid_pc;
          w_state_nxt    = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    if (w_flush) begin
      w_p_inst_nxt = NOP_INST;
      w_p_pc_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_VECTOR;
      r_kill_tgt <= '0;
      r_p_pc     <= '0;
      r_p_inst   <= NOP_INST;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_kill_tgt <= w_kill_tgt_nxt;
      r_p_pc     <= w_p_pc_nxt;
      r_p_inst   <= w_p_inst_nxt;
    end
  end

`ifdef CPU_IF_PERF_EN
  logic        w_fetch_used;
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  // Only FETCH-state completions without a redirect reach decode or the skid.
  assign w_fetch_used = (r_state == S_FETCH) && imem_rdy && !ex_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_fetch_used) r_perf_fetch  <= r_perf_fetch + 32'd1;
      if (w_flush)      r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_fetch  = r_perf_fetch;
  assign perf_bubble = r_perf_bubble;
`endif

endmodule

// File: tb/tb_cpu_if.sv
// Directed bench for cpu_if: an instruction memory with adjustable latency
// (word n holds 32'h2000_0000+n) plus per-scenario tasks with inline checks.
module tb_cpu_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data = '0;
  logic        imem_rdy = 1'b0;
  logic [31:0] p_pc;
  logic [31:0] p_inst;

  int checks = 0;
  int errors = 0;
  bit auto_mem = 1'b1;
  int lat = 0;
  int wait_cnt = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  cpu_if dut (
    .clk         (clk),
    .rst         (rst),
    .c_stall     (c_stall),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_data   (imem_data),
    .imem_rdy    (imem_rdy),
    .p_pc        (p_pc),
    .p_inst      (p_inst)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2000_0000 + {2'b00, a[31:2]};
  endfunction

  // Completes a request after lat extra wait cycles.
  task automatic mem_update();
    if (!imem_req) begin
      imem_rdy = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= lat) begin
      imem_rdy  = 1'b1;
      imem_data = mem_word(imem_addr);
      wait_cnt  = 0;
    end else begin
      imem_rdy  = 1'b0;
      imem_data = 32'h0BAD_0000;
      wait_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (auto_mem) mem_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; c_stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    auto_mem = 1'b1; lat = 0; wait_cnt = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (p_inst !== NOP) begin errors++; $display("FAIL rst_inst got %h want %h", p_inst, NOP); end
    checks++; if (p_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", p_pc); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (p_inst !== 32'h2000_0000 + n) begin errors++; $display("FAIL zw_inst%0d got %h want %h", n, p_inst, 32'h2000_0000 + n); end
      checks++; if (p_pc !== 32'(4 * (n + 1))) begin errors++; $display("FAIL zw_pc%0d got %h want %h", n, p_pc, 4 * (n + 1)); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    lat = 2;
    for (int n = 0; n < 3; n++) begin
      for (int b = 0; b < 2; b++) begin
        tick();
        checks++; if (p_inst !== NOP || p_pc !== 32'h0) begin errors++; $display("FAIL lat_bub%0d_%0d got %h/%h want %h/0", n, b, p_inst, p_pc, NOP); end
        checks++; if (imem_addr !== 32'(4 * n) || imem_req !== 1'b1) begin errors++; $display("FAIL lat_addr%0d_%0d got %h req %b want %h req 1", n, b, imem_addr, imem_req, 4 * n); end
      end
      tick();
      checks++; if (p_inst !== 32'h2000_0000 + n || p_pc !== 32'(4 * n + 4)) begin errors++; $display("FAIL lat_inst%0d got %h/%h want %h/%h", n, p_inst, p_pc, 32'h2000_0000 + n, 4 * n + 4); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    c_stall = 1'b1;
    tick();
    checks++; if (p_inst !== 32'h2000_0001 || p_pc !== 32'h8) begin errors++; $display("FAIL st_hold1 got %h/%h want 20000001/8", p_inst, p_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_skid_req got %b want 0", imem_req); end
    tick();
    checks++; if (p_inst !== 32'h2000_0001 || p_pc !== 32'h8) begin errors++; $display("FAIL st_hold2 got %h/%h want 20000001/8", p_inst, p_pc); end
    c_stall = 1'b0;
    tick();
    checks++; if (p_inst !== 32'h2000_0002 || p_pc !== 32'hC) begin errors++; $display("FAIL st_release got %h/%h want 20000002/c", p_inst, p_pc); end
    tick();
    checks++; if (p_inst !== 32'h2000_0003 || p_pc !== 32'h10) begin errors++; $display("FAIL st_next got %h/%h want 20000003/10", p_inst, p_pc); end
  endtask

  task automatic test_redirect_kill();
    do_reset();
    for (int n = 0; n < 4; n++) tick();
    checks++; if (p_inst !== 32'h2000_0003 || imem_addr !== 32'h10) begin errors++; $display("FAIL rk_pre got %h addr %h want 20000003 addr 10", p_inst, imem_addr); end
    lat = 2;
    ex_redirect = 1'b1; ex_target = 32'h0000_0103;
    tick();
    ex_redirect = 1'b0;
    checks++; if (p_inst !== NOP || p_pc !== 32'h0) begin errors++; $display("FAIL rk_flush got %h/%h want %h/0", p_inst, p_pc, NOP); end
    checks++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin errors++; $display("FAIL rk_hold1 got %h req %b want 10 req 1", imem_addr, imem_req); end
    tick();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL rk_hold2 got %h want 10", imem_addr); end
    tick();
    checks++; if (p_inst !== NOP) begin errors++; $display("FAIL rk_drop got %h want %h", p_inst, NOP); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL rk_target got %h want 100", imem_addr); end
    tick(); tick(); tick();
    checks++; if (p_inst !== 32'h2000_0040 || p_pc !== 32'h104) begin errors++; $display("FAIL rk_first got %h/%h want 20000040/104", p_inst, p_pc); end
  endtask

  task automatic test_kill_latest();
    do_reset();
    lat = 2;
    ex_redirect = 1'b1; ex_target = 32'h0000_0103;
    tick();
    ex_target = 32'h0000_02FE;
    tick();
    ex_redirect = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL kl_hold got %h want 0", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h2FC || p_inst !== NOP) begin errors++; $display("FAIL kl_latest got %h inst %h want 2fc inst %h", imem_addr, p_inst, NOP); end
  endtask

  task automatic test_skid_redirect();
    do_reset();
    tick();
    c_stall = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0 || p_inst !== 32'h2000_0000) begin errors++; $display("FAIL sr_skid got req %b inst %h want 0/20000000", imem_req, p_inst); end
    ex_redirect = 1'b1; ex_target = 32'h0000_0040;
    tick();
    ex_redirect = 1'b0; c_stall = 1'b0;
    checks++; if (p_inst !== NOP || p_pc !== 32'h0) begin errors++; $display("FAIL sr_flush got %h/%h want %h/0", p_inst, p_pc, NOP); end
    checks++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin errors++; $display("FAIL sr_target got %h req %b want 40 req 1", imem_addr, imem_req); end
    tick();
    checks++; if (p_inst !== 32'h2000_0010 || p_pc !== 32'h44) begin errors++; $display("FAIL sr_first got %h/%h want 20000010/44", p_inst, p_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFF;
    tick();
    ex_redirect = 1'b0;
    checks++; if (p_inst !== NOP || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_redir got %h addr %h want %h addr fffffffc", p_inst, imem_addr, NOP); end
    tick();
    checks++; if (p_inst !== 32'h5FFF_FFFF || p_pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_top got %h/%h addr %h want 5fffffff/0 addr 0", p_inst, p_pc, imem_addr); end
    tick();
    checks++; if (p_inst !== 32'h2000_0000 || p_pc !== 32'h4) begin errors++; $display("FAIL wr_zero got %h/%h want 20000000/4", p_inst, p_pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick();
    lat = 2;
    tick();
    rst = 1'b1; auto_mem = 1'b0; imem_rdy = 1'b1; imem_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rm_req got %b want 0", imem_req); end
    tick();
    checks++; if (p_inst !== NOP || p_pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rm_state got %h/%h req %b want %h/0 req 0", p_inst, p_pc, imem_req, NOP); end
    rst = 1'b0; imem_rdy = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL rm_addr got %h req %b want 0 req 1", imem_addr, imem_req); end
    auto_mem = 1'b1; lat = 0; wait_cnt = 0;
    tick();
    checks++; if (p_inst !== 32'h2000_0000 || p_pc !== 32'h4) begin errors++; $display("FAIL rm_first got %h/%h want 20000000/4", p_inst, p_pc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_kill();
    test_kill_latest();
    test_skid_redirect();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
